// File: rtl/riscv_pkg.sv
// Shared RISC-V decode types used by the decode-side pipeline stages.
// Holds the immediate-kind encoding consumed by the immediate generator.
// Pure type definitions; no logic, no latency, no flow control.
package riscv_pkg;

    // Immediate kinds selectable by decode; IMM_Z (CSR uimm) and IMM_SH
    // (shift amount) are zero-extended, everything else sign-extends.
    // Encoding 3'd7 is left undefined and is flagged as an error downstream.
    typedef enum logic [2:0] {
        IMM_I  = 3'd0,
        IMM_S  = 3'd1,
        IMM_B  = 3'd2,
        IMM_U  = 3'd3,
        IMM_J  = 3'd4,
        IMM_Z  = 3'd5,
        IMM_SH = 3'd6
    } immediate_type_e;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for the immediate-extend stage: decode side in, execute side out.
// No latency; pure wiring between producer, stage and consumer.
// Both sides use valid/ready; master drives the inputs, slave is the stage.
interface imm_extend_pipe_if
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    // upstream (decode) side
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    immediate_type_e   in_src;
    logic [TAG_W-1:0]  in_tag;

    // downstream (execute) side
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_imm;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;

    // the stage itself
    modport slave (
        input  in_valid, in_instr, in_src, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_err
    );

    // whoever feeds the stage and drains its output
    modport master (
        output in_valid, in_instr, in_src, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_err
    );

endinterface

// File: rtl/imm_extend_pipe.sv
// Registered RV immediate generator with tag/err sideband, 2-entry skid buffer.
// Latency: 1 cycle from accept to out_valid when empty; full throughput when draining.
// Backpressure: in_ready is a flop (low only while the skid entry is occupied).
module imm_extend_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    imm_extend_pipe_if.slave   bus
);

    // Only RV32 and RV64 datapaths are meaningful for this stage.
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_extend_pipe: XLEN must be 32 or 64");
    end

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } payload_t;

    state_e    state;
    payload_t  main_q;
    payload_t  skid_q;
    payload_t  in_pl;
    logic      in_ready_q;
    logic      out_valid_q;
    logic      accept;
    logic      emit;
    logic [XLEN-1:0] ext_imm;
    logic            ext_err;

    // Opcode bits never contribute to an immediate.
    logic unused_opcode_bits;
    assign unused_opcode_bits = ^bus.in_instr[6:0];

    // Immediate extraction; undefined kinds give a clean zero plus err so no X leaks.
    always_comb begin
        ext_imm = '0;
        ext_err = 1'b0;
        case (bus.in_src)
            IMM_I:  ext_imm = XLEN'($signed(bus.in_instr[31:20]));
            IMM_S:  ext_imm = XLEN'($signed({bus.in_instr[31:25], bus.in_instr[11:7]}));
            IMM_B:  ext_imm = XLEN'($signed({bus.in_instr[31], bus.in_instr[7],
                                              bus.in_instr[30:25], bus.in_instr[11:8], 1'b0}));
            IMM_U:  ext_imm = XLEN'($signed({bus.in_instr[31:12], 12'b0}));
            IMM_J:  ext_imm = XLEN'($signed({bus.in_instr[31], bus.in_instr[19:12],
                                              bus.in_instr[20], bus.in_instr[30:21], 1'b0}));
            IMM_Z:  ext_imm = XLEN'(bus.in_instr[19:15]);
            // RV64 shifts take a 6-bit shamt; RV32 ignores instr[25].
            IMM_SH: ext_imm = (XLEN == 64) ? XLEN'(bus.in_instr[25:20])
                                           : XLEN'(bus.in_instr[24:20]);
            default: begin
                ext_imm = '0;
                ext_err = 1'b1;
            end
        endcase
    end

    assign in_pl = {ext_imm, bus.in_tag, ext_err};

    // A flush kills both handshakes in its own cycle.
    assign accept = bus.in_valid & in_ready_q & ~flush;
    assign emit   = out_valid_q & bus.out_ready & ~flush;

    // Skid-buffer control: main feeds the outputs, skid absorbs one entry of stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            // Data registers keep stale contents; out_valid=0 masks them.
            state       <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        main_q      <= in_pl;
                        out_valid_q <= 1'b1;
                        state       <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (emit && accept) begin
                        main_q <= in_pl;
                    end else if (emit) begin
                        out_valid_q <= 1'b0;
                        state       <= ST_EMPTY;
                    end else if (accept) begin
                        skid_q     <= in_pl;
                        in_ready_q <= 1'b0;
                        state      <= ST_TWO;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only the drain side can move.
                    if (emit) begin
                        main_q     <= skid_q;
                        in_ready_q <= 1'b1;
                        state      <= ST_ONE;
                    end
                end
                default: begin
                    state       <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_imm   = main_q.imm;
    assign bus.out_tag   = main_q.tag;
    assign bus.out_err   = main_q.err;

endmodule
